// File: rtl/nv_nvdla_stub_pkg.sv
// Shared definitions for the NVDLA stub unit: CSB payload field positions,
// register word indices, response encodings and the op FSM state type.
package nv_nvdla_stub_pkg;

  localparam int CSB_PD_W    = 63;
  localparam int ADDR_LSB    = 0;
  localparam int ADDR_W      = 22;
  localparam int WDAT_LSB    = 22;
  localparam int WDAT_W      = 32;
  localparam int WRITE_BIT   = 54;
  localparam int NPOSTED_BIT = 55;

  localparam int CSB_RESP_W    = 34;
  localparam int RESP_TYPE_BIT = 33;
  localparam int RESP_ERR_BIT  = 32;

  localparam int REG_OP_ENABLE = 0;
  localparam int REG_OP_DELAY  = 1;
  localparam int REG_RSP_CNT   = 2;

  localparam logic RESP_TYPE_READ  = 1'b0;
  localparam logic RESP_TYPE_WRITE = 1'b1;

  typedef enum logic [0:0] {
    OP_IDLE = 1'b0,
    OP_BUSY = 1'b1
  } op_state_e;

endpackage

// File: rtl/nv_nvdla_stub_csb_chan.sv
// One CSB slave channel of the stub unit: address decode, register bank and
// registered response. Optional NVDLA_STUB_ERR_RESP_EN enables error responses.
module nv_nvdla_stub_csb_chan
  import nv_nvdla_stub_pkg::*;
#(
  parameter int CH_IDX    = 0,
  parameter int REG_DEPTH = 16,
  parameter int CNT_W     = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_pvld,
  input  logic [CSB_PD_W-1:0]   req_pd,
  input  logic                  busy,
  input  logic [31:0]           rsp_cnt,
  output logic                  resp_valid,
  output logic [CSB_RESP_W-1:0] resp_pd,
  output logic                  op_start,
  output logic [CNT_W-1:0]      op_delay,
  output logic                  cnt_clr
);

  localparam int          AW       = $clog2(REG_DEPTH);
  localparam bit          IS_CORE  = (CH_IDX == 0);
  localparam logic [31:0] DLY_MASK = 32'((64'd1 << CNT_W) - 64'd1);

  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdat;
  logic              is_write;
  logic              nposted;
  logic [AW-1:0]     idx;
  logic              out_of_range;
  logic              cnt_wr_err;
  logic              wr_en;
  logic              hit_en, hit_dly, hit_cnt;
  logic              need_rsp;
  logic [31:0]       rdata;
  logic [31:0]       regs [REG_DEPTH];

  assign addr     = req_pd[ADDR_LSB +: ADDR_W];
  assign wdat     = req_pd[WDAT_LSB +: WDAT_W];
  assign is_write = req_pd[WRITE_BIT];
  assign nposted  = req_pd[NPOSTED_BIT];
  assign idx      = addr[AW-1:0];

`ifdef NVDLA_STUB_ERR_RESP_EN
  assign out_of_range = |addr[ADDR_W-1:AW];
  assign cnt_wr_err   = IS_CORE && is_write && (idx == AW'(REG_RSP_CNT));
`else
  assign out_of_range = 1'b0;
  assign cnt_wr_err   = 1'b0;
`endif

  assign hit_en   = (idx == AW'(REG_OP_ENABLE));
  assign hit_dly  = (idx == AW'(REG_OP_DELAY));
  assign hit_cnt  = (idx == AW'(REG_RSP_CNT));
  assign wr_en    = req_pvld && is_write && !out_of_range;
  assign need_rsp = req_pvld && (!is_write || nposted);

  assign op_start = IS_CORE && wr_en && hit_en && wdat[0];
  assign cnt_clr  = IS_CORE && wr_en && hit_cnt;
  assign op_delay = regs[REG_OP_DELAY][CNT_W-1:0];

  // Channel 0 words 0 and 2 are live views of top-level state, never stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_DEPTH; i++) regs[i] <= '0;
    end else if (wr_en) begin
      if (IS_CORE && hit_dly) regs[idx] <= wdat & DLY_MASK;
      else if (!(IS_CORE && (hit_en || hit_cnt))) regs[idx] <= wdat;
    end
  end

  always_comb begin
    rdata = regs[idx];
    if (IS_CORE && hit_en) rdata = {31'b0, busy};
    else if (IS_CORE && hit_cnt) rdata = rsp_cnt;
    if (out_of_range) rdata = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid <= 1'b0;
      resp_pd    <= '0;
    end else begin
      resp_valid <= need_rsp;
      if (need_rsp) begin
        resp_pd <= {is_write ? RESP_TYPE_WRITE : RESP_TYPE_READ,
                    out_of_range || cnt_wr_err,
                    is_write ? 32'd0 : rdata};
      end
    end
  end

  logic unused_bits;
  assign unused_bits = ^{req_pd[CSB_PD_W-1:NPOSTED_BIT+1], addr, busy, rsp_cnt};

endmodule

// File: rtl/nv_nvdla_stub_unit.sv
// Live stand-in for an absent NVDLA sub-unit: per-channel CSB register banks,
// op-done timer interrupt and DMA read-response sink. Option: NVDLA_STUB_ERR_RESP_EN.
module nv_nvdla_stub_unit
  import nv_nvdla_stub_pkg::*;
#(
  parameter int NUM_CSB   = 2,
  parameter int REG_DEPTH = 16,
  parameter int RSP_PD_W  = 257,
  parameter int CNT_W     = 16
) (
  input  logic                           nvdla_core_clk,
  input  logic                           nvdla_core_rstn,
  input  logic [NUM_CSB-1:0]             csb_req_pvld,
  output logic [NUM_CSB-1:0]             csb_req_prdy,
  input  logic [NUM_CSB*CSB_PD_W-1:0]    csb_req_pd,
  output logic [NUM_CSB-1:0]             csb_resp_valid,
  output logic [NUM_CSB*CSB_RESP_W-1:0]  csb_resp_pd,
  input  logic                           dma_rd_rsp_valid,
  output logic                           dma_rd_rsp_ready,
  input  logic [RSP_PD_W-1:0]            dma_rd_rsp_pd,
  output logic                           dma_rd_req_valid,
  output logic                           dma_wr_req_valid,
  output logic [1:0]                     done_intr_pd,
  output op_state_e                      op_state_dbg
);

  // Handshakes: a CSB request transfers on pvld&&prdy (prdy is always 1);
  // responses are single-cycle valid pulses with no back-pressure; a DMA beat
  // transfers on dma_rd_rsp_valid&&dma_rd_rsp_ready (ready is always 1).
  assign csb_req_prdy     = '1;
  assign dma_rd_rsp_ready = 1'b1;
  assign dma_rd_req_valid = 1'b0;
  assign dma_wr_req_valid = 1'b0;

  op_state_e                     state_q, state_d;
  logic [CNT_W-1:0]              cnt_q, cnt_d;
  logic                          group_q, group_d;
  logic [31:0]                   rsp_cnt_q;
  logic                          busy;
  logic [NUM_CSB-1:0]            ch_op_start;
  logic [NUM_CSB-1:0][CNT_W-1:0] ch_op_delay;
  logic [NUM_CSB-1:0]            ch_cnt_clr;

  assign busy         = (state_q == OP_BUSY);
  assign op_state_dbg = state_q;

  for (genvar c = 0; c < NUM_CSB; c++) begin : g_chan
    nv_nvdla_stub_csb_chan #(
      .CH_IDX   (c),
      .REG_DEPTH(REG_DEPTH),
      .CNT_W    (CNT_W)
    ) u_chan (
      .clk       (nvdla_core_clk),
      .rst_n     (nvdla_core_rstn),
      .req_pvld  (csb_req_pvld[c]),
      .req_pd    (csb_req_pd[c*CSB_PD_W +: CSB_PD_W]),
      .busy      (busy),
      .rsp_cnt   (rsp_cnt_q),
      .resp_valid(csb_resp_valid[c]),
      .resp_pd   (csb_resp_pd[c*CSB_RESP_W +: CSB_RESP_W]),
      .op_start  (ch_op_start[c]),
      .op_delay  (ch_op_delay[c]),
      .cnt_clr   (ch_cnt_clr[c])
    );
  end

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      state_q <= OP_IDLE;
      cnt_q   <= '0;
      group_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      group_q <= group_d;
    end
  end

  // Op enable writes while busy are ignored, so a running op is never restarted.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    group_d = group_q;
    case (state_q)
      OP_IDLE: begin
        if (ch_op_start[0]) begin
          state_d = OP_BUSY;
          cnt_d   = ch_op_delay[0];
        end
      end
      OP_BUSY: begin
        if (cnt_q == '0) begin
          state_d = OP_IDLE;
          group_d = ~group_q;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = OP_IDLE;
    endcase
  end

  always_comb begin
    done_intr_pd = 2'b00;
    if (state_q == OP_BUSY && cnt_q == '0) done_intr_pd[group_q] = 1'b1;
  end

  // A clearing write wins over a beat arriving in the same cycle.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      rsp_cnt_q <= '0;
    end else if (ch_cnt_clr[0]) begin
      rsp_cnt_q <= '0;
    end else if (dma_rd_rsp_valid && dma_rd_rsp_ready && rsp_cnt_q != 32'hFFFF_FFFF) begin
      rsp_cnt_q <= rsp_cnt_q + 32'd1;
    end
  end

  logic unused_top;
  assign unused_top = ^{dma_rd_rsp_pd, ch_op_start, ch_op_delay, ch_cnt_clr};

endmodule
